quantum_timer_mc: RTL and testbench
===================================

// Module: quantum_timer_mc
// PURPOSE
//  Multi-channel time-quantum timer for the scheduler datapath. Each of NCH channels holds a
//  reload quantum and down-counts it, emitting a one-cycle expiry pulse per elapsed quantum.
//  Adds over the single-channel generation: channel count, per-channel enable/stop,
//  load handshake with restart/deferred modes, zero-quantum rejection and count readback.
// PARAMETERS
//  WIDTH     23  quantum/counter width in bits
//  NCH       4   number of independent channels (1..16)
//  CHW       2   channel index width, = clog2(NCH), min 1
//  PRESCALE  16  tick divider; used only when QT_PRESCALE_EN is defined (>=1)
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          synchronous, active-high
//  ld_valid    in   1          quantum load request
//  ld_ready    out  1          load accept; handshake completes on ld_valid & ld_ready
//  ld_ch       in   CHW        target channel of load
//  ld_val      in   WIDTH      new quantum in ticks; 0 is illegal
//  ld_restart  in   1          1: restart count now; 0: apply at next reload
//  ld_err      out  1          1-cycle pulse: load accepted with ld_val==0 or ld_ch>=NCH, discarded
//  ch_en       in   NCH        per-channel count enable (freeze when 0)
//  ch_stop     in   NCH        per-channel synchronous stop
//  expire      out  NCH        per-channel 1-cycle expiry pulse (registered)
//  expire_any  out  1          registered OR of expire
//  ch_run      out  NCH        channel in RUN state
//  rd_ch       in   CHW        readback select
//  rd_count    out  WIDTH      combinational cnt[rd_ch]; 0 if rd_ch>=NCH
// BEHAVIOUR
//  - Reset: cnt=0, hold=0, state IDLE all channels; ld_ready=0, ld_err=0, expire=0, expire_any=0,
//    ch_run=0. ld_ready goes 1 on the first edge with reset low and stays 1; reset wins everywhere.
//  - Per-channel FSM: IDLE -> RUN on accepted legal load; RUN -> IDLE on ch_stop; else hold.
//  - tick = 1 every cycle (see CONFIGURATION). Counting when RUN & ch_en & tick:
//    cnt!=1: cnt<=cnt-1. cnt==1: cnt<=hold, expire[i]=1 next cycle. Period = hold ticks exactly.
//  - ch_en=0: cnt frozen, no expiry; resuming continues from frozen value.
//  - Legal load (ld_val!=0, ld_ch<NCH): hold<=ld_val. If ld_restart or IDLE: cnt<=ld_val, RUN.
//    If RUN & !ld_restart: cnt unaffected; new hold used at next reload.
//  - Illegal load: consumed (ready stays 1), ld_err pulses next cycle, no state change.
//  - Same-cycle priority per channel: reset > ch_stop > load restart > count.
//    Stop+load same channel: channel IDLE, cnt=0, hold still updated, no expire.
//    Restart load on cycle with cnt==1: no expire, cnt<=ld_val.
//    Deferred load on cycle with cnt==1: expire asserted, reload uses NEW ld_val.
//  - ch_stop: cnt<=0, state IDLE, hold retained; pending expire pulse of that cycle suppressed.
//  - Multiple channels may expire on the same cycle; all bits assert.
// CONFIGURATION
//  QT_PRESCALE_EN defined: shared counter pre (width clog2(PRESCALE)+1), tick=1 one cycle in
//   PRESCALE; pre resets to 0, tick on pre==PRESCALE-1 then wraps to 0; free-running regardless
//   of ch_en. Loads/stops act every cycle, not gated by tick.
//  QT_PRESCALE_EN undefined: no prescaler logic, tick=1 always, PRESCALE ignored.
// TESTING
//  1 reset 3 cycles -> all outputs 0; ld_ready=1 first cycle after reset release.
//  2 load ch0 val=3 restart -> expire[0] every 3 cycles, rd_count 3,2,1,3..., expire_any matches.
//  3 ch1 running val=5, deferred load val=2 at cnt=3 -> expire at old period once, then every 2.
//  4 load ld_val=0 and ld_ch=NCH -> ld_err pulse each, ch_run/cnt unchanged.
//  5 ch2 val=4, ch_en low 3 cycles mid-count -> expiry delayed 3 cycles; ch_stop at cnt==1 -> no expire, cnt=0.
//  6 QT_PRESCALE_EN, PRESCALE=4, val=2 -> expire every 8 cycles; reset mid-count -> all cleared.

Source files
------------

// File: rtl/quantum_timer_mc.sv
// Multi-channel time-quantum timer: each channel down-counts a reload quantum and pulses expire once per elapsed quantum.
// Latency: expire/expire_any/ld_err are registered, one cycle after the deciding edge; rd_count is combinational.
// Backpressure: ld_ready is held low in reset and high afterwards, so every load is consumed, including illegal ones.
//
// Ports: clk/reset (sync, active-high); ld_valid/ld_ready/ld_ch/ld_val/ld_restart load handshake;
//        ld_err illegal-load pulse; ch_en/ch_stop per-channel enable/stop; expire/expire_any expiry
//        pulses; ch_run RUN state per channel; rd_ch/rd_count count readback.
// Optional feature: define QT_PRESCALE_EN to advance the counters only one cycle in PRESCALE.
module quantum_timer_mc #(
  parameter int WIDTH    = 23,
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int PRESCALE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [CHW-1:0]   ld_ch,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             ld_restart,
  output logic             ld_err,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   ch_stop,
  output logic [NCH-1:0]   expire,
  output logic             expire_any,
  output logic [NCH-1:0]   ch_run,
  input  logic [CHW-1:0]   rd_ch,
  output logic [WIDTH-1:0] rd_count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [WIDTH-1:0] cnt_q   [NCH];
  logic [WIDTH-1:0] cnt_d   [NCH];
  logic [WIDTH-1:0] hold_q  [NCH];
  logic [WIDTH-1:0] hold_d  [NCH];
  logic [NCH-1:0]   exp_d;
  logic [NCH-1:0]   ld_hit;
  logic             ld_fire;
  logic             ld_legal;
  logic             tick;

`ifdef QT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE) + 1;
  logic [PW-1:0] pre;

  // Free-running divider shared by all channels; independent of ch_en.
  always_ff @(posedge clk) begin
    if (reset)                          pre <= '0;
    else if (pre == PW'(PRESCALE - 1))  pre <= '0;
    else                                pre <= pre + 1'b1;
  end

  assign tick = (pre == PW'(PRESCALE - 1));
`else
  assign tick = 1'b1;
`endif

  assign ld_fire  = ld_valid & ld_ready;
  assign ld_legal = (ld_val != '0) && (int'(ld_ch) < NCH);

  always_comb begin
    ld_hit = '0;
    exp_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hold_d[i]  = hold_q[i];
      ld_hit[i]  = ld_fire && ld_legal && (int'(ld_ch) == i);

      // The quantum is captured even when a stop wins the same cycle.
      if (ld_hit[i]) hold_d[i] = ld_val;

      if (ch_stop[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else if (ld_hit[i] && (ld_restart || state_q[i] == IDLE)) begin
        state_d[i] = RUN;
        cnt_d[i]   = ld_val;
      end else if (state_q[i] == RUN && ch_en[i] && tick) begin
        if (cnt_q[i] == WIDTH'(1)) begin
          // A deferred load landing on the terminal count reloads with the new quantum.
          cnt_d[i] = ld_hit[i] ? ld_val : hold_q[i];
          exp_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
      expire     <= '0;
      expire_any <= 1'b0;
      ld_ready   <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
      end
      expire     <= exp_d;
      expire_any <= |exp_d;
      ld_ready   <= 1'b1;
      ld_err     <= ld_fire & ~ld_legal;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_run[i] = (state_q[i] == RUN);
  end

  always_comb begin
    rd_count = '0;
    if (int'(rd_ch) < NCH) rd_count = cnt_q[rd_ch];
  end

endmodule

// File: tb/tb_quantum_timer_mc.sv
module tb_quantum_timer_mc;

  localparam int W = 23;
  localparam int N = 3;
  localparam int C = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ld_valid = 1'b0;
  logic         ld_ready;
  logic [C-1:0] ld_ch = '0;
  logic [W-1:0] ld_val = '0;
  logic         ld_restart = 1'b0;
  logic         ld_err;
  logic [N-1:0] ch_en = '1;
  logic [N-1:0] ch_stop = '0;
  logic [N-1:0] expire;
  logic         expire_any;
  logic [N-1:0] ch_run;
  logic [C-1:0] rd_ch = '0;
  logic [W-1:0] rd_count;

  quantum_timer_mc #(.WIDTH(W), .NCH(N), .CHW(C), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ch(ld_ch), .ld_val(ld_val),
    .ld_restart(ld_restart), .ld_err(ld_err),
    .ch_en(ch_en), .ch_stop(ch_stop),
    .expire(expire), .expire_any(expire_any), .ch_run(ch_run),
    .rd_ch(rd_ch), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [C-1:0] ch;
    logic [W-1:0] val;
    logic         rs;
    logic [N-1:0] en;
    logic [N-1:0] stop;
    logic [C-1:0] rd;
    logic [N-1:0] e_exp;
    logic         e_any;
    logic [N-1:0] e_run;
    logic [W-1:0] e_cnt;
    logic         e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
  endtask

  function automatic vec_t mk(input logic v, input int ch, input int val, input logic rs,
                              input int en, input int stop, input int rd, input int e_exp,
                              input logic e_any, input int e_run, input int e_cnt, input logic e_err);
    vec_t t;
    t.v = v; t.ch = C'(ch); t.val = W'(val); t.rs = rs; t.en = N'(en); t.stop = N'(stop);
    t.rd = C'(rd); t.e_exp = N'(e_exp); t.e_any = e_any; t.e_run = N'(e_run);
    t.e_cnt = W'(e_cnt); t.e_err = e_err;
    return t;
  endfunction

  function automatic vec_t idl(input int rd, input int e_exp, input int e_run, input int e_cnt);
    return mk(1'b0, 0, 0, 1'b0, 7, 0, rd, e_exp, (e_exp != 0), e_run, e_cnt, 1'b0);
  endfunction

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    ld_valid = t.v; ld_ch = t.ch; ld_val = t.val; ld_restart = t.rs;
    ch_en = t.en; ch_stop = t.stop; rd_ch = t.rd;
    sb.push_back(t);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("row%0d expire", idx),     32'(expire),     32'(e.e_exp));
    chk($sformatf("row%0d expire_any", idx), 32'(expire_any), 32'(e.e_any));
    chk($sformatf("row%0d ch_run", idx),     32'(ch_run),     32'(e.e_run));
    chk($sformatf("row%0d rd_count", idx),   32'(rd_count),   32'(e.e_cnt));
    chk($sformatf("row%0d ld_err", idx),     32'(ld_err),     32'(e.e_err));
    chk($sformatf("row%0d ld_ready", idx),   32'(ld_ready),   32'd1);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, " expire"},     32'(expire),     32'd0);
    chk({nm, " expire_any"}, 32'(expire_any), 32'd0);
    chk({nm, " ch_run"},     32'(ch_run),     32'd0);
    chk({nm, " ld_err"},     32'(ld_err),     32'd0);
    chk({nm, " ld_ready"},   32'(ld_ready),   32'd0);
    chk({nm, " rd_count"},   32'(rd_count),   32'd0);
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_ch = '0; ld_val = '0; ld_restart = 1'b0;
    ch_en = '1; ch_stop = '0; rd_ch = '0;
  endtask

  initial begin
    // Columns: v ch val rs en stop rd | expire any run rd_count err
    tbl.push_back(idl(0, 0, 0, 0));                           // ready rises, nothing loaded yet
    tbl.push_back(mk(1, 0, 3, 1, 7, 0, 0, 0, 0, 1, 3, 0));    // ch0 val=3 restart
    tbl.push_back(idl(0, 0, 1, 2));
    tbl.push_back(idl(0, 0, 1, 1));
    tbl.push_back(idl(0, 1, 1, 3));
    tbl.push_back(idl(0, 0, 1, 2));
    tbl.push_back(idl(0, 0, 1, 1));
    tbl.push_back(idl(0, 1, 1, 3));
    tbl.push_back(mk(1, 1, 5, 1, 7, 0, 1, 0, 0, 3, 5, 0));    // ch1 val=5 restart
    tbl.push_back(idl(1, 0, 3, 4));
    tbl.push_back(idl(1, 1, 3, 3));
    tbl.push_back(mk(1, 1, 2, 0, 7, 0, 1, 0, 0, 3, 2, 0));    // deferred val=2 at cnt=3
    tbl.push_back(idl(1, 0, 3, 1));
    tbl.push_back(idl(1, 3, 3, 2));                           // both channels expire together
    tbl.push_back(idl(1, 0, 3, 1));
    tbl.push_back(idl(1, 2, 3, 2));
    tbl.push_back(idl(1, 1, 3, 1));
    tbl.push_back(idl(1, 2, 3, 2));
    tbl.push_back(mk(0, 0, 0, 0, 7, 3, 1, 0, 0, 0, 0, 0));    // stop ch0 and ch1
    tbl.push_back(mk(1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1));    // zero quantum
    tbl.push_back(mk(1, 3, 7, 1, 7, 0, 3, 0, 0, 0, 0, 1));    // channel out of range
    tbl.push_back(idl(3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3, 1, 7, 0, 0, 0, 0, 1, 3, 0));
    tbl.push_back(idl(0, 0, 1, 2));
    tbl.push_back(idl(0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 5, 0, 7, 0, 0, 1, 1, 1, 5, 0));    // deferred at cnt==1: expire, new value
    tbl.push_back(idl(0, 0, 1, 4));
    tbl.push_back(idl(0, 0, 1, 3));
    tbl.push_back(idl(0, 0, 1, 2));
    tbl.push_back(idl(0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 2, 1, 7, 0, 0, 0, 0, 1, 2, 0));    // restart at cnt==1: no expire
    tbl.push_back(idl(0, 0, 1, 1));
    tbl.push_back(idl(0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0));    // stop ch0
    tbl.push_back(mk(1, 2, 4, 1, 7, 0, 2, 0, 0, 4, 4, 0));    // ch2 val=4
    tbl.push_back(idl(2, 0, 4, 3));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 2, 0, 0, 4, 3, 0));    // ch2 frozen 3 cycles
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 2, 0, 0, 4, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 2, 0, 0, 4, 3, 0));
    tbl.push_back(idl(2, 0, 4, 2));
    tbl.push_back(idl(2, 0, 4, 1));
    tbl.push_back(idl(2, 4, 4, 4));
    tbl.push_back(idl(2, 0, 4, 3));
    tbl.push_back(idl(2, 0, 4, 2));
    tbl.push_back(idl(2, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 7, 4, 2, 0, 0, 0, 0, 0));    // stop at cnt==1: no expire
    tbl.push_back(mk(1, 2, 6, 1, 7, 4, 2, 0, 0, 0, 0, 0));    // stop beats load
    tbl.push_back(mk(1, 0, 9, 1, 7, 0, 0, 0, 0, 1, 9, 0));
    tbl.push_back(idl(0, 0, 1, 8));

    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      chk_cleared($sformatf("reset%0d", r));
    end
    reset = 1'b0;

`ifndef QT_PRESCALE_EN
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);
    idle_inputs();
    // Reset in the middle of a running count clears everything again.
    reset = 1'b1;
    @(posedge clk); #1;
    chk_cleared("midreset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postreset ld_ready", 32'(ld_ready), 32'd1);
    chk("postreset ch_run",   32'(ch_run),   32'd0);
`else
    begin
      int t_first;
      int t_second;
      bit seen;
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_ch = '0; ld_val = W'(2); ld_restart = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      chk("pre load ch_run", 32'(ch_run), 32'd1);
      chk("pre load rd_count", 32'(rd_count), 32'd2);
      t_first = 0; t_second = 0; seen = 0;
      for (int c = 1; c <= 40 && t_second == 0; c++) begin
        if (expire[0]) begin
          if (!seen) begin t_first = c; seen = 1; end
          else t_second = c;
        end
        if (t_second == 0) begin @(posedge clk); #1; end
      end
      chk("pre first expire seen", 32'(seen), 32'd1);
      chk("pre expire period", 32'(t_second - t_first), 32'd8);
      chk("pre expire_any", 32'(expire_any), 32'd1);
      @(posedge clk); #1;
      chk("pre no double pulse", 32'(expire), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_cleared("pre midreset");
      reset = 1'b0;
      @(posedge clk); #1;
      chk("pre postreset ld_ready", 32'(ld_ready), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
